// File: rtl/wb_pack_sat.sv
// wb_pack_sat: sums partial sums per channel, shifts, clamps, optional ReLU,
// packs LANES results per BRAM word and walks a row/stride address pattern.
module wb_pack_sat #(
  parameter int NUM_CH    = 2,
  parameter int NUM_TERMS = 5,
  parameter int IN_W      = 19,
  parameter int OUT_W     = 8,
  parameter int LANES     = 8,
  parameter int ADDR_W    = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_CH*ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]                   words_per_row,
  input  logic [ADDR_W-1:0]                   row_stride,
  input  logic [4:0]                          shift,
  input  logic                                relu_en,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CH*NUM_TERMS*IN_W-1:0]    sum_in,
  input  logic                                flush,
  input  logic                                finish,
  output logic                                we,
  output logic [NUM_CH*ADDR_W-1:0]            addr,
  output logic [NUM_CH*LANES*OUT_W-1:0]       din,
  output logic                                busy,
  output logic                                done
);

  localparam int WW = LANES * OUT_W;
  localparam int SW = IN_W + $clog2(NUM_TERMS);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_FLUSH_WR,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic   is_fin;

  logic                     s1_valid;
  logic [NUM_CH*SW-1:0]     s1_sum;
  logic [NUM_CH*SW-1:0]     sum_nx;
  logic [NUM_CH*OUT_W-1:0]  lane_v;
  logic [NUM_CH*WW-1:0]     pack;
  logic [NUM_CH*WW-1:0]     pack_nx;
  logic [LW-1:0]            lane_cnt;
  logic                     full;

  logic [NUM_CH*ADDR_W-1:0] row_start;
  logic [NUM_CH*ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0]        word_cnt;

  logic accept;
  logic start_acc;
  logic wr_part;
  logic do_wr;
  logic row_adv;
  logic norm_adv;
  logic last_word;

  assign in_ready  = (state == S_RUN);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

  // Partial word only closes at the end of DRAIN2, once the pipe is empty.
  assign wr_part   = (state == S_DRAIN2) && !full && (lane_cnt != '0);
  assign do_wr     = full || wr_part;
  assign row_adv   = (state == S_DRAIN2) && (wr_part || !is_fin);
  assign norm_adv  = full && !row_adv;
  assign last_word = (word_cnt >= words_per_row - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      is_fin <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_RUN && (flush || finish))
        is_fin <= finish;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (start) state_nx = S_RUN;
      S_RUN:      if (flush || finish) state_nx = S_DRAIN1;
      S_DRAIN1:   state_nx = S_DRAIN2;
      S_DRAIN2:   state_nx = S_FLUSH_WR;
      S_FLUSH_WR: state_nx = is_fin ? S_DONE : S_RUN;
      S_DONE:     if (start) state_nx = S_RUN;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sum_nx = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int t = 0; t < NUM_TERMS; t++)
        sum_nx[c*SW +: SW] = sum_nx[c*SW +: SW]
          + SW'($signed(sum_in[(c*NUM_TERMS+t)*IN_W +: IN_W]));
  end

  always_comb begin
    logic signed [SW-1:0] v;
    v      = '0;
    lane_v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = $signed(s1_sum[c*SW +: SW]) >>> shift;
      if (v > MAXV)
        v = MAXV;
      else if (v < MINV)
        v = MINV;
      if (relu_en && v < 0)
        v = '0;
      lane_v[c*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
  end

  // A full word leaves on this edge, so the next lane 0 lands in a clean word.
  always_comb begin
    pack_nx = (full || wr_part) ? '0 : pack;
    if (s1_valid)
      for (int c = 0; c < NUM_CH; c++)
        pack_nx[c*WW + WW - 1 - int'(lane_cnt)*OUT_W -: OUT_W] =
          lane_v[c*OUT_W +: OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      pack     <= '0;
      lane_cnt <= '0;
      full     <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      din      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept)
        s1_sum <= sum_nx;
      we <= do_wr;
      if (do_wr) begin
        din  <= pack;
        addr <= cur_addr;
      end
      if (start_acc) begin
        pack     <= '0;
        lane_cnt <= '0;
        full     <= 1'b0;
      end else begin
        pack <= pack_nx;
        full <= s1_valid && (lane_cnt == LAST_LANE);
        if (s1_valid)
          lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
        else if (wr_part)
          lane_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_start <= '0;
      cur_addr  <= '0;
      word_cnt  <= '0;
    end else if (start_acc) begin
      row_start <= base_addr;
      cur_addr  <= base_addr;
      word_cnt  <= '0;
    end else if (row_adv || (norm_adv && last_word)) begin
      for (int c = 0; c < NUM_CH; c++) begin
        row_start[c*ADDR_W +: ADDR_W] <=
          row_start[c*ADDR_W +: ADDR_W] + row_stride;
        cur_addr[c*ADDR_W +: ADDR_W] <=
          row_start[c*ADDR_W +: ADDR_W] + row_stride;
      end
      word_cnt <= '0;
    end else if (norm_adv) begin
      for (int c = 0; c < NUM_CH; c++)
        cur_addr[c*ADDR_W +: ADDR_W] <=
          cur_addr[c*ADDR_W +: ADDR_W] + 1'b1;
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule
